// File: rtl/delta_sched.sv
// delta_sched: two requesters share one 2-to-8-bit sign extender and one
// 8-bit adder to accumulate signed positions. A three-state FSM
// (IDLE -> EXT -> ACK) serves one request at a time, arbitrates
// round-robin on ties, and can saturate or wrap on overflow.
module delta_sched #(
    parameter bit         SAT  = 1'b1,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       Clk,
    input  logic       Clear_n,
    input  logic       Req0,
    input  logic       Req1,
    input  logic [1:0] Delta0,
    input  logic [1:0] Delta1,
    output logic       Ack0,
    output logic       Ack1,
    output logic [7:0] Pos0,
    output logic [7:0] Pos1,
    output logic       Busy,
    output logic       Sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXT  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state;
    logic       sel;       // index of the requester being served
    logic       last;      // index of the last granted requester
    logic [1:0] dlat;      // delta captured at grant time

    logic       grant_sel;
    logic [7:0] pos_cur;
    logic [7:0] ext;
    logic [8:0] sum;
    logic       ovf;
    logic [7:0] pos_new;

    // Round-robin grant: a sole requester wins; on a tie the index that
    // did not win last time is granted.
    always_comb begin
        grant_sel = 1'b0;
        if (Req0 && Req1) begin
            grant_sel = ~last;
        end else begin
            grant_sel = Req1;
        end
    end

    // Shared datapath: select the served position, sign-extend the
    // latched delta, add in 9 bits and apply the overflow policy.
    always_comb begin
        pos_cur = sel ? Pos1 : Pos0;
        ext     = {{6{dlat[1]}}, dlat};
        sum     = {pos_cur[7], pos_cur} + {ext[7], ext};
        // The 9-bit result overflows 8 bits when its top two bits differ.
        ovf     = sum[8] ^ sum[7];
        pos_new = sum[7:0];
        if (ovf && SAT) begin
            pos_new = sum[8] ? 8'h80 : 8'h7F;
        end
    end

    // Control FSM with registered outputs and position registers.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
            dlat  <= '0;
            Pos0  <= INIT;
            Pos1  <= INIT;
            Ack0  <= 1'b0;
            Ack1  <= 1'b0;
            Busy  <= 1'b0;
            Sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Ack0 <= 1'b0;
                    Ack1 <= 1'b0;
                    Sat  <= 1'b0;
                    if (Req0 || Req1) begin
                        sel   <= grant_sel;
                        dlat  <= grant_sel ? Delta1 : Delta0;
                        Busy  <= 1'b1;
                        state <= EXT;
                    end else begin
                        Busy  <= 1'b0;
                    end
                end
                EXT: begin
                    if (sel) begin
                        Pos1 <= pos_new;
                    end else begin
                        Pos0 <= pos_new;
                    end
                    last  <= sel;
                    Sat   <= ovf;
                    Ack0  <= ~sel;
                    Ack1  <= sel;
                    Busy  <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    Ack0  <= 1'b0;
                    Ack1  <= 1'b0;
                    Sat   <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Ack0  <= 1'b0;
                    Ack1  <= 1'b0;
                    Sat   <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delta_sched.sv
// Testbench for delta_sched: one saturating and one wrapping instance share
// the same stimulus and are checked against a transaction-level model.
module tb_delta_sched;

    logic       Clk = 1'b0;
    logic       Clear_n;
    logic       Req0, Req1;
    logic [1:0] Delta0, Delta1;

    logic [1:0] ack  [2];
    logic [7:0] pos  [2][2];
    logic       busy [2];
    logic       sat  [2];

    int unsigned nerr = 0;
    int unsigned nchk = 0;

    // Model state: [instance][requester], instance 0 saturates, 1 wraps.
    int         mpos [2][2];
    int         last;
    bit         req_q [2];
    logic [1:0] dl_q  [2];

    always #5 Clk = ~Clk;

    delta_sched #(.SAT(1'b1), .INIT(8'h00)) u_sat (
        .Clk(Clk), .Clear_n(Clear_n),
        .Req0(Req0), .Req1(Req1), .Delta0(Delta0), .Delta1(Delta1),
        .Ack0(ack[0][0]), .Ack1(ack[0][1]),
        .Pos0(pos[0][0]), .Pos1(pos[0][1]),
        .Busy(busy[0]), .Sat(sat[0])
    );

    delta_sched #(.SAT(1'b0), .INIT(8'h00)) u_wrap (
        .Clk(Clk), .Clear_n(Clear_n),
        .Req0(Req0), .Req1(Req1), .Delta0(Delta0), .Delta1(Delta1),
        .Ack0(ack[1][0]), .Ack1(ack[1][1]),
        .Pos0(pos[1][0]), .Pos1(pos[1][1]),
        .Busy(busy[1]), .Sat(sat[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Next position from plain integer arithmetic and the overflow policy.
    function automatic int next_pos(input int p, input int d, input bit sat_mode,
                                    output bit ov);
        int s;
        s  = p + d;
        ov = (s > 127) || (s < -128);
        if (!ov)      return s;
        if (sat_mode) return (s > 127) ? 127 : -128;
        return (s > 127) ? s - 256 : s + 256;
    endfunction

    task automatic drive();
        Req0   = req_q[0];
        Req1   = req_q[1];
        Delta0 = dl_q[0];
        Delta1 = dl_q[1];
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mpos[k][0] = 0;
            mpos[k][1] = 0;
        end
        last = 1;
    endtask

    task automatic check_quiet(input string where);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_busy_i%0d", where, k), int'(busy[k]), 0);
            chk($sformatf("%s_ack0_i%0d", where, k), int'(ack[k][0]), 0);
            chk($sformatf("%s_ack1_i%0d", where, k), int'(ack[k][1]), 0);
            chk($sformatf("%s_sat_i%0d", where, k), int'(sat[k]), 0);
            chk($sformatf("%s_pos0_i%0d", where, k), int'($signed(pos[k][0])), mpos[k][0]);
            chk($sformatf("%s_pos1_i%0d", where, k), int'($signed(pos[k][1])), mpos[k][1]);
        end
    endtask

    // One grant, starting at a negedge with the DUT idle and requests driven.
    task automatic serve(input bit resub, input logic [1:0] newd, input bit scramble);
        int w;
        int d;
        int e  [2];
        bit ov [2];
        if (req_q[0] && req_q[1]) w = (last == 0) ? 1 : 0;
        else                      w = req_q[0] ? 0 : 1;
        d = int'($signed(dl_q[w]));
        for (int k = 0; k < 2; k++) e[k] = next_pos(mpos[k][w], d, (k == 0), ov[k]);

        @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ext_busy_i%0d", k), int'(busy[k]), 1);
            chk($sformatf("ext_ack0_i%0d", k), int'(ack[k][0]), 0);
            chk($sformatf("ext_ack1_i%0d", k), int'(ack[k][1]), 0);
        end
        if (scramble) begin
            if (w == 0) Delta0 = 2'($urandom);
            else        Delta1 = 2'($urandom);
        end

        @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ack_win%0d_i%0d", w, k), int'(ack[k][w]), 1);
            chk($sformatf("ack_lose%0d_i%0d", 1 - w, k), int'(ack[k][1 - w]), 0);
            chk($sformatf("pos_win%0d_i%0d", w, k), int'($signed(pos[k][w])), e[k]);
            chk($sformatf("pos_other%0d_i%0d", 1 - w, k),
                int'($signed(pos[k][1 - w])), mpos[k][1 - w]);
            chk($sformatf("sat_i%0d", k), int'(sat[k]), int'(ov[k]));
            chk($sformatf("ack_busy_i%0d", k), int'(busy[k]), 1);
            mpos[k][w] = e[k];
        end
        last = w;

        @(posedge Clk);
        #1;
        req_q[w] = resub;
        if (resub) dl_q[w] = newd;
        drive();
        @(negedge Clk);
        check_quiet("post_ack");
    endtask

    task automatic do_reset();
        Clear_n  = 1'b0;
        req_q[0] = 1'b0;
        req_q[1] = 1'b0;
        drive();
        model_reset();
        @(negedge Clk);
        Clear_n = 1'b1;
        @(negedge Clk);
        check_quiet("reset");
    endtask

    // Reset asserted 'depth' cycles into a transaction (1 = EXT, 2 = ACK).
    task automatic reset_in(input int depth);
        req_q[0] = 1'b1;
        dl_q[0]  = 2'b01;
        drive();
        repeat (depth) @(negedge Clk);
        if (depth == 2) chk("pre_reset_ack0", int'(ack[0][0]), 1);
        Clear_n = 1'b0;
        #1;
        model_reset();
        check_quiet($sformatf("midreset_d%0d", depth));
        @(negedge Clk);
        check_quiet($sformatf("midreset_hold_d%0d", depth));
        Clear_n = 1'b1;
        serve(1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        Clear_n = 1'b0;
        req_q[0] = 1'b0; req_q[1] = 1'b0;
        dl_q[0]  = 2'b00; dl_q[1]  = 2'b00;
        drive();
        model_reset();
        repeat (3) @(negedge Clk);
        check_quiet("in_reset");
        Clear_n = 1'b1;
        @(negedge Clk);
        check_quiet("after_release");

        // Single request, +1.
        req_q[0] = 1'b1; dl_q[0] = 2'b01; drive();
        serve(1'b0, 2'b00, 1'b0);

        // Contention after reset, then a second tie.
        do_reset();
        req_q[0] = 1'b1; req_q[1] = 1'b1; dl_q[0] = 2'b10; dl_q[1] = 2'b11; drive();
        serve(1'b0, 2'b00, 1'b0);
        serve(1'b0, 2'b00, 1'b0);
        req_q[0] = 1'b1; req_q[1] = 1'b1; dl_q[0] = 2'b01; dl_q[1] = 2'b01; drive();
        serve(1'b0, 2'b00, 1'b0);
        serve(1'b0, 2'b00, 1'b0);

        // Positive overflow: 127 steps to 8'h7F, then two more +1.
        do_reset();
        repeat (129) begin
            req_q[0] = 1'b1; dl_q[0] = 2'b01; drive();
            serve(1'b0, 2'b00, 1'b0);
        end

        // Negative overflow: 64 steps of -2 to 8'h80, then one more.
        do_reset();
        repeat (65) begin
            req_q[0] = 1'b1; dl_q[0] = 2'b10; drive();
            serve(1'b0, 2'b00, 1'b0);
        end

        // Zero delta on requester 1.
        req_q[1] = 1'b1; dl_q[1] = 2'b00; drive();
        serve(1'b0, 2'b00, 1'b0);

        // Reset during EXT and during ACK.
        do_reset();
        reset_in(1);
        do_reset();
        reset_in(2);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_q[r] && ($urandom_range(2) != 0)) begin
                    req_q[r] = 1'b1;
                    dl_q[r]  = 2'($urandom);
                end
            end
            drive();
            if (!req_q[0] && !req_q[1]) begin
                @(negedge Clk);
                check_quiet("idle");
            end else begin
                serve(($urandom_range(3) == 0), 2'($urandom), $urandom_range(1) == 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/delta_sched.md
DELTA_SCHED -- requirements
Module: delta_sched

Interface
REQ-001 Parameter: SAT, default 1, overflow mode (1 = saturate, 0 = wrap modulo 256).
REQ-002 Parameter: INIT, default 8'h00, reset value of Pos0 and Pos1.
REQ-003 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-004 Clear_n  input  1  asynchronous, active-low reset.
REQ-005 Req0, Req1  input  1 each  request from requester 0 / 1.
REQ-006 Delta0, Delta1  input  2 each  signed two's-complement increment (-2..+1) from requester 0 / 1.
REQ-007 Ack0, Ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-008 Pos0, Pos1  output  8 each  signed accumulated position of requester 0 / 1.
REQ-009 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 Sat  output  1  one-cycle overflow flag, coincident with the Ack of the overflowing transaction.

Function
REQ-011 The block SHALL share one 2-to-8-bit sign extender and one 8-bit adder between the two requesters.
REQ-012 FSM states SHALL be IDLE, EXT and ACK; every state change SHALL occur on posedge Clk.
REQ-013 IDLE: if no Req is high, stay in IDLE; else grant one requester, latch its index (Sel) and Delta, go to EXT.
REQ-014 Arbitration SHALL be round-robin on Last (index of last granted requester): sole requester wins; if both request, grant the index != Last.
REQ-015 On Req0 and Req1 both high, Last SHALL decide the grant and no request SHALL be lost; the loser stays pending until served.
REQ-016 EXT: sign-extend latched delta by replicating bit 1 into bits 7:2 (2'b10 -> 8'hFE, 2'b11 -> 8'hFF, 2'b01 -> 8'h01, 2'b00 -> 8'h00).
REQ-017 EXT: form the 9-bit signed sum Pos[Sel] + ext; overflow is sum > 127 or sum < -128.
REQ-018 Overflow with SAT=1: write 8'h7F (positive) or 8'h80 (negative); SAT=0: write the low 8 bits.
REQ-019 EXT: on the same edge, update Pos[Sel], set Last <= Sel, latch the overflow flag, and go to ACK.
REQ-020 ACK: assert Ack[Sel] (Moore) for exactly one cycle, Sat = latched overflow flag, then go to IDLE unconditionally.
REQ-021 Latency: Req sampled in IDLE at edge E0 -> Pos updated at E1 -> Ack high during E1..E2 -> IDLE at E2.
REQ-022 Updated Pos SHALL be visible in the same cycle as its Ack.
REQ-023 Requester protocol: Req and Delta SHALL be held stable from assertion until Ack is seen; Req drops at the edge ending the Ack cycle.
REQ-024 Req still high in IDLE after its Ack SHALL be served as a new transaction.
REQ-025 Delta changes after grant SHALL be ignored; only the value latched in IDLE is used.
REQ-026 The non-selected Pos SHALL never change, and Ack0 and Ack1 SHALL never be high together.
REQ-027 Delta 2'b00 SHALL complete a normal transaction: Ack pulses, Pos is unchanged, Sat = 0.
REQ-028 Maximum throughput SHALL be one transaction per 3 cycles.

Reset
REQ-029 Clear_n low SHALL immediately force: state IDLE, Pos0 = Pos1 = INIT, Ack0 = Ack1 = 0, Busy = 0, Sat = 0, Last = 1 (requester 0 wins first tie).
REQ-030 Reset asserted in EXT or ACK SHALL discard the transaction: no Ack, and Pos takes INIT, not the partial result.
REQ-031 After Clear_n rises, the first IDLE sampling edge SHALL accept requests normally.

Verification
REQ-032 Reset: Clear_n=0, then release -> Pos0=Pos1=8'h00, Ack0=Ack1=0, Busy=0, Sat=0.
REQ-033 Single request: Req0=1, Delta0=2'b01 at E0 -> Busy from E0, Pos0=8'h01 and Ack0=1 during E1..E2, IDLE at E2.
REQ-034 Contention after reset: Req0=Req1=1, Delta0=2'b10, Delta1=2'b11.
  -> Ack0 first with Pos0=8'hFE; then Ack1 with Pos1=8'hFF.
  -> Next tie is granted to requester 0 again.
REQ-035 Saturation: drive Pos0 to 8'h7F, then Delta0=2'b01.
  -> SAT=1: Pos0 stays 8'h7F, Sat=1 with Ack0.
  -> SAT=0: Pos0=8'h80, Sat=1.
  -> Same for Pos0=8'h80 with Delta0=2'b10: 8'h80 (SAT=1) / 8'h7E (SAT=0).
REQ-036 Reset mid-operation: Clear_n=0 while in EXT -> no Ack pulse, Pos0=8'h00, Busy=0; next request completes normally.
REQ-037 Zero delta: Req1=1, Delta1=2'b00 -> Ack1 pulses, Pos1 unchanged, Sat=0.
